// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Operands are registered at grant; the result is held in a single-entry response buffer.
module alu_arbiter #(
    parameter int  WIDTH = 16,
    parameter int  NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id,
    output logic [2:0]            alu_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_result,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   ptr_nxt;
    logic             found;
    logic             transfer;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign ptr_nxt  = (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
    assign transfer = (state == IDLE) && found && !rst;
    assign busy     = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (transfer)
            req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand capture at grant, result capture at the end of the EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            id_q       <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        alu_op <= sel_op;
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        id_q   <= grant;
                        rr_ptr <= ptr_nxt;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_result;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready)
                        resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [IDW-1:0] resp_id;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_result;
    logic           busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return a;
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return a + 1'b1;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    // Pending request contents per requester
    logic [2:0]   p_op [N];
    logic [W-1:0] p_a  [N];
    logic [W-1:0] p_b  [N];

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < N; i++) begin
            req_op[3*i +: 3] = p_op[i];
            req_a[W*i +: W]  = p_a[i];
            req_b[W*i +: W]  = p_b[i];
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: one transaction in flight, aged in cycles since acceptance
    int           m_age;     // -1 free, 1 executing, 2 response pending
    int           m_ptr;
    int           m_id;
    int           m_rid;
    logic [2:0]   m_op;
    logic [W-1:0] m_a, m_b, m_rd;

    // Values sampled mid-cycle by step
    int           obs_grant;
    logic         s_valid, s_busy;
    logic [W-1:0] s_data;
    logic [IDW-1:0] s_id;
    logic [N-1:0] s_ready;
    int           cyc = 0;
    int           regen = -1;
    bit           rand_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_age = -1; m_ptr = 0; m_id = 0; m_rid = 0;
        m_op = '0; m_a = '0; m_b = '0; m_rd = '0;
    endtask

    task automatic new_req(input int i);
        p_op[i] = 3'($urandom_range(0, 7));
        p_a[i]  = W'($urandom);
        p_b[i]  = W'($urandom);
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic rr);
        int eg;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        if (regen >= 0 && rand_mode) new_req(regen);
        regen = -1;
        rst = r; req_valid = v; resp_ready = rr;
        #1;
        eg = -1;
        if (!r && m_age < 0)
            for (int k = 0; k < N; k++)
                if (eg < 0 && v[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
        exp_ready = (eg >= 0) ? N'(1 << eg) : '0;
        chk("req_ready",  32'(req_ready),  32'(exp_ready));
        chk("busy",       32'(busy),       32'(m_age >= 0));
        chk("resp_valid", 32'(resp_valid), 32'(m_age == 2));
        chk("resp_data",  32'(resp_data),  32'(m_rd));
        chk("resp_id",    32'(resp_id),    32'(m_rid));
        chk("alu_op",     32'(alu_op),     32'(m_op));
        chk("alu_a",      32'(alu_a),      32'(m_a));
        chk("alu_b",      32'(alu_b),      32'(m_b));
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) obs_grant = i;
        s_valid = resp_valid; s_busy = busy; s_data = resp_data; s_id = resp_id; s_ready = req_ready;
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
        end else if (eg >= 0) begin
            m_op = p_op[eg]; m_a = p_a[eg]; m_b = p_b[eg];
            m_id = eg; m_ptr = (eg + 1) % N; m_age = 1;
            regen = eg;
        end else if (m_age == 1) begin
            m_rd = alu_fn(m_op, m_a, m_b); m_rid = m_id; m_age = 2;
        end else if (m_age == 2 && rr) begin
            m_age = -1;
        end
    endtask

    task automatic run_one(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp, input string nm);
        p_op[i] = op; p_a[i] = a; p_b[i] = b;
        step(0, N'(1 << i), 1);
        chk({nm, "_grant"}, 32'(obs_grant), 32'(i));
        step(0, '0, 1);
        chk({nm, "_exec_valid"}, 32'(s_valid), 32'd0);
        step(0, '0, 1);
        chk({nm, "_valid"}, 32'(s_valid), 32'd1);
        chk({nm, "_data"},  32'(s_data),  32'(exp));
        chk({nm, "_id"},    32'(s_id),    32'(i));
        step(0, '0, 1);
        chk({nm, "_busy_fall"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        int gl[$], gc[$], ids[$];
        int exp_order[5];
        logic [W-1:0] d0;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; end
        rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        step(1, '0, 1);
        step(0, '0, 1);
        chk("reset_busy",  32'(s_busy),  32'd0);
        chk("reset_valid", 32'(s_valid), 32'd0);
        chk("reset_ready", 32'(s_ready), 32'd0);

        // Single op and modulo wrap cases
        run_one(0, 3'd5, 16'h0003, 16'h0004, 16'h0007, "add");
        run_one(1, 3'd5, 16'hFFFF, 16'h0001, 16'h0000, "add_wrap");
        run_one(2, 3'd6, 16'h0000, 16'h0001, 16'hFFFF, "sub_wrap");
        run_one(3, 3'd7, 16'hFFFF, 16'h0000, 16'h0000, "inc_wrap");

        // Round robin with all requesters valid
        step(1, '0, 1);
        for (int i = 0; i < N; i++) begin p_op[i] = 3'd5; p_a[i] = W'(i); p_b[i] = W'(16'h100); end
        for (int s = 0; s < 15; s++) begin
            step(0, 4'hF, 1);
            if (obs_grant >= 0) begin gl.push_back(obs_grant); gc.push_back(cyc); end
            if (s_valid) ids.push_back(int'(s_id));
        end
        chk("rr_grants", 32'(gl.size()), 32'd5);
        chk("rr_resps",  32'(ids.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gl.size()) chk("rr_order", 32'(gl[i]), 32'(exp_order[i]));
            if (i < ids.size()) chk("rr_resp_id", 32'(ids[i]), 32'(exp_order[i]));
            if (i > 0 && i < gc.size()) chk("rr_spacing", 32'(gc[i] - gc[i-1]), 32'd3);
        end

        // Sparse wrap: grant 2, then 0101 -> 0 then 2
        step(1, '0, 1);
        step(0, 4'b0100, 1); chk("sparse_g2", 32'(obs_grant), 32'd2);
        step(0, '0, 1); step(0, '0, 1);
        step(0, 4'b0101, 1); chk("sparse_g0", 32'(obs_grant), 32'd0);
        step(0, 4'b0101, 1); step(0, 4'b0101, 1);
        step(0, 4'b0101, 1); chk("sparse_g2b", 32'(obs_grant), 32'd2);
        step(0, '0, 1); step(0, '0, 1);

        // Backpressure
        step(1, '0, 1);
        p_op[0] = 3'd2; p_a[0] = 16'hA5A5; p_b[0] = 16'h0FF0;
        step(0, 4'hF, 1); chk("bp_grant", 32'(obs_grant), 32'd0);
        step(0, 4'hF, 0);
        d0 = 16'hAA55;
        for (int s = 0; s < 5; s++) begin
            step(0, 4'hF, 0);
            chk("bp_valid", 32'(s_valid), 32'd1);
            chk("bp_data",  32'(s_data),  32'(d0));
            chk("bp_id",    32'(s_id),    32'd0);
            chk("bp_ready", 32'(s_ready), 32'd0);
        end
        step(0, 4'hF, 1); chk("bp_handshake_ready", 32'(s_ready), 32'd0);
        step(0, 4'hF, 1); chk("bp_resume", 32'(obs_grant), 32'd1);
        step(0, '0, 1); step(0, '0, 1);

        // Reset during EXEC
        step(1, '0, 1);
        step(0, 4'b0100, 1); chk("rst_g2", 32'(obs_grant), 32'd2);
        step(1, '0, 1);
        for (int s = 0; s < 3; s++) begin
            step(0, '0, 1);
            chk("rst_valid", 32'(s_valid), 32'd0);
            chk("rst_busy",  32'(s_busy),  32'd0);
        end
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        step(0, 4'hF, 1); chk("rst_next_g0", 32'(obs_grant), 32'd0);
        step(0, '0, 1); step(0, '0, 1);

        // Randomized traffic
        rand_mode = 1;
        for (int i = 0; i < N; i++) new_req(i);
        for (int s = 0; s < 3000; s++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 6);
            step(($urandom_range(0, 99) == 0), v, ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
